keypad_key_decoder: RTL

Sits directly downstream of the matrix keypad row scanner. It samples the scanner's row drive and column sense on each scan tick and debounces the raw {row,col} code. It emits a one-cycle key event carrying a 4-bit key value, keeps a 4-digit entry history, and drives an active-low seven-segment pattern for the most recent key. It runs entirely in the fast system clock domain; the scanner's slow advance arrives as a one-cycle `scan_tick` strobe.

---
 rtl/keypad_pkg.sv | 76 +++++++
 rtl/hex_to_sevenseg.sv | 13 +
 rtl/keypad_key_decoder.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types, key map and segment decode for the keypad key decoder.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        PRESSED
    } state_t;

    typedef enum logic [1:0] {
        SMP_EMPTY,
        SMP_VALID,
        SMP_MULTI
    } sample_t;

    localparam logic [3:0] KEY_CLEAR = 4'hE;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Indexed by {row bit, col bit}; entry 15 is row bit 3 / col bit 3.
    localparam logic [15:0][3:0] KEY_LUT = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    function automatic logic [1:0] onehot_pos(input logic [3:0] v);
        logic [1:0] p;
        p = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (v[i]) p = 2'(i);
        end
        return p;
    endfunction

    // code is {row[3:0], col[3:0]}, both assumed one-hot.
    function automatic logic [3:0] key_of(input logic [7:0] code);
        return KEY_LUT[{onehot_pos(code[7:4]), onehot_pos(code[3:0])}];
    endfunction

    function automatic sample_t classify(input logic [3:0] row, input logic [3:0] col);
        sample_t s;
        if (col == '0)                       s = SMP_EMPTY;
        else if ($onehot(row) && $onehot(col)) s = SMP_VALID;
        else                                 s = SMP_MULTI;
        return s;
    endfunction

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == '1) ? v : v + 4'd1;
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] value);
        logic [6:0] s;
        case (value)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/hex_to_sevenseg.sv
// Combinational 4-bit value to active-low seven-segment pattern (bit6=a .. bit0=g).
module hex_to_sevenseg
    import keypad_pkg::*;
(
    input  logic [3:0] value_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = seg_of(value_i);
    end

endmodule

// File: rtl/keypad_key_decoder.sv
// Debounces keypad scanner samples into key events, a 4-digit history and a 7-seg pattern.
// Optional auto-repeat while held is enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_key_decoder
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS = 3,
`ifdef KEYPAD_AUTOREPEAT_EN
    parameter int unsigned REPEAT_DELAY   = 8,
    parameter int unsigned REPEAT_RATE    = 4,
`endif
    parameter int unsigned RELEASE_TICKS  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scan_tick,
    input  logic [3:0]  scan_row,
    input  logic [3:0]  scan_col,
    output logic        key_valid,
    output logic [3:0]  key_value,
    output logic        key_held,
    output logic        multi_err,
    output logic [15:0] digits,
    output logic [6:0]  sevenseg
);

    localparam logic [3:0] DEB_N = 4'(DEBOUNCE_TICKS);
    localparam logic [3:0] REL_N = 4'(RELEASE_TICKS);

    state_t      state_q, state_d;
    logic [7:0]  cand_q, cand_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  rcnt_q, rcnt_d;
    logic        key_valid_q, multi_err_q, merr_d;
    logic [3:0]  key_value_q, key_value_d;
    logic [15:0] digits_q, digits_d;
    logic [6:0]  seg_q, seg_d, seg_dec;

    logic        fire;
    logic [7:0]  fire_code;
    logic [3:0]  fire_value;
    logic [7:0]  sample;
    sample_t     smp;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam logic [7:0] REP_DLY  = 8'(REPEAT_DELAY);
    localparam logic [7:0] REP_RATE = 8'(REPEAT_RATE);

    logic [7:0]  rep_q, rep_d;
    logic        rep_armed_q, rep_armed_d;
`endif

    assign sample = {scan_row, scan_col};
    assign smp    = classify(scan_row, scan_col);

    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        rcnt_d    = rcnt_q;
        merr_d    = 1'b0;
        fire      = 1'b0;
        fire_code = cand_q;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_d       = rep_q;
        rep_armed_d = rep_armed_q;
`endif

        if (scan_tick) begin
            case (state_q)
                IDLE: begin
                    if (smp == SMP_VALID) begin
                        cand_d    = sample;
                        cnt_d     = 4'd1;
                        fire_code = sample;
                        // A one-tick debounce accepts the very first valid sample.
                        if (DEB_N <= 4'd1) begin
                            fire    = 1'b1;
                            cnt_d   = '0;
                            state_d = PRESSED;
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end else if (smp == SMP_MULTI) begin
                        merr_d = 1'b1;
                    end
                end

                DEBOUNCE: begin
                    if (smp == SMP_VALID) begin
                        if (sample == cand_q) begin
                            cnt_d = sat_inc4(cnt_q);
                            if (cnt_d >= DEB_N) begin
                                fire    = 1'b1;
                                cnt_d   = '0;
                                state_d = PRESSED;
                            end
                        end else begin
                            cand_d = sample;
                            cnt_d  = 4'd1;
                        end
                    end else if (smp == SMP_EMPTY) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        merr_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end

                PRESSED: begin
                    if (smp == SMP_EMPTY) begin
                        rcnt_d = sat_inc4(rcnt_q);
                        if (rcnt_d >= REL_N) begin
                            rcnt_d  = '0;
                            state_d = IDLE;
                        end
                    end else begin
                        rcnt_d = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_d = (rep_q == '1) ? rep_q : rep_q + 8'd1;
                        if (rep_armed_q ? (rep_d >= REP_RATE) : (rep_d >= REP_DLY)) begin
                            fire        = 1'b1;
                            fire_code   = cand_q;
                            rep_d       = '0;
                            rep_armed_d = 1'b1;
                        end
`endif
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase

`ifdef KEYPAD_AUTOREPEAT_EN
            if (state_q != PRESSED && state_d == PRESSED) begin
                rep_d       = '0;
                rep_armed_d = 1'b0;
            end
`endif
        end
    end

    // The decoder sees the next key value so the segment register updates on the event edge.
    always_comb begin
        fire_value  = key_of(fire_code);
        key_value_d = fire ? fire_value : key_value_q;
        digits_d    = digits_q;
        seg_d       = seg_q;
        if (fire) begin
            digits_d = (fire_value == KEY_CLEAR) ? '0 : {digits_q[11:0], fire_value};
            seg_d    = seg_dec;
        end
    end

    hex_to_sevenseg u_seg (
        .value_i (key_value_d),
        .seg_o   (seg_dec)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cand_q      <= '0;
            cnt_q       <= '0;
            rcnt_q      <= '0;
            key_valid_q <= 1'b0;
            multi_err_q <= 1'b0;
            key_value_q <= '0;
            digits_q    <= '0;
            seg_q       <= SEG_BLANK;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            rcnt_q      <= rcnt_d;
            key_valid_q <= fire;
            multi_err_q <= merr_d;
            key_value_q <= key_value_d;
            digits_q    <= digits_d;
            seg_q       <= seg_d;
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            rep_q       <= '0;
            rep_armed_q <= 1'b0;
        end else begin
            rep_q       <= rep_d;
            rep_armed_q <= rep_armed_d;
        end
    end
`endif

    assign key_valid = key_valid_q;
    assign multi_err = multi_err_q;
    assign key_value = key_value_q;
    assign key_held  = (state_q == PRESSED);
    assign digits    = digits_q;
    assign sevenseg  = seg_q;

endmodule
